// File: rtl/sm_key_debounce.sv
// Push-button debouncer: two-flop synchronizer, four-state debounce FSM, registered level/press/release outputs.
// Optional auto-repeat of key_press while held is enabled by defining SM_KEY_DEBOUNCE_AUTOREPEAT_EN.
module sm_key_debounce #(
   parameter int CNT_WIDTH       = 20,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REP_WIDTH       = 26,
   parameter int REPEAT_DELAY    = 50000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_state,
   output logic key_press,
   output logic key_release
);

   typedef enum logic [1:0] {
      UP       = 2'd0,
      DEB_DOWN = 2'd1,
      DOWN     = 2'd2,
      DEB_UP   = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   state_t               state_reg, state_next;
   logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
   logic                 sync1_reg, sync2_reg;
   logic                 key_s;
   logic                 press_next, release_next, level_next;
   logic                 rep_fire;

   // Synchronizer flops idle high so reset looks like a released key.
   assign key_s = ~sync2_reg;

`ifdef SM_KEY_DEBOUNCE_AUTOREPEAT_EN
   localparam logic [REP_WIDTH-1:0] REP_DELAY_LAST  = REP_WIDTH'(REPEAT_DELAY - 1);
   localparam logic [REP_WIDTH-1:0] REP_PERIOD_LAST = REP_WIDTH'(REPEAT_PERIOD - 1);

   logic [REP_WIDTH-1:0] rep_cnt_reg, rep_cnt_next;
   logic                 rep_armed_reg, rep_armed_next;
   logic [REP_WIDTH-1:0] rep_limit;

   // First repeat waits the long delay, later ones use the short period.
   assign rep_limit = rep_armed_reg ? REP_PERIOD_LAST : REP_DELAY_LAST;
   assign rep_fire  = (state_reg == DOWN) && key_s && (rep_cnt_reg == rep_limit);

   always_comb begin
      rep_cnt_next   = rep_cnt_reg;
      rep_armed_next = rep_armed_reg;
      case (state_reg)
         UP, DEB_DOWN: begin
            rep_cnt_next   = '0;
            rep_armed_next = 1'b0;
         end
         DOWN: begin
            if (key_s) begin
               if (rep_fire) begin
                  rep_cnt_next   = '0;
                  rep_armed_next = 1'b1;
               end else begin
                  rep_cnt_next = rep_cnt_reg + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt_reg   <= '0;
         rep_armed_reg <= 1'b0;
      end else begin
         rep_cnt_reg   <= rep_cnt_next;
         rep_armed_reg <= rep_armed_next;
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      press_next   = 1'b0;
      release_next = 1'b0;
      case (state_reg)
         UP: begin
            if (key_s) begin
               state_next = DEB_DOWN;
               cnt_next   = '0;
            end
         end
         DEB_DOWN: begin
            if (!key_s) begin
               state_next = UP;
            end else if (cnt_reg == DEB_LAST) begin
               state_next = DOWN;
               press_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DOWN: begin
            if (!key_s) begin
               state_next = DEB_UP;
               cnt_next   = '0;
            end else if (rep_fire) begin
               press_next = 1'b1;
            end
         end
         DEB_UP: begin
            if (key_s) begin
               state_next = DOWN;
            end else if (cnt_reg == DEB_LAST) begin
               state_next   = UP;
               release_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: state_next = UP;
      endcase
      level_next = (state_next == DOWN) || (state_next == DEB_UP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg   <= 1'b1;
         sync2_reg   <= 1'b1;
         state_reg   <= UP;
         cnt_reg     <= '0;
         key_state   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         sync1_reg   <= key_n;
         sync2_reg   <= sync1_reg;
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         key_state   <= level_next;
         key_press   <= press_next;
         key_release <= release_next;
      end
   end

endmodule

// File: tb/tb_sm_key_debounce.sv
// Bench for sm_key_debounce: directed scenarios plus random bouncing, checked against a run-length model.
// Define SM_KEY_DEBOUNCE_AUTOREPEAT_EN for both files to exercise auto-repeat.
module tb_sm_key_debounce;
   localparam int DEB     = 4;
   localparam int RDELAY  = 10;
   localparam int RPERIOD = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic key_n = 1'b1;
   logic key_state, key_press, key_release;

   always #5 clk = ~clk;

   sm_key_debounce #(
      .CNT_WIDTH      (3),
      .DEBOUNCE_CYCLES(DEB),
      .REP_WIDTH      (4),
      .REPEAT_DELAY   (RDELAY),
      .REPEAT_PERIOD  (RPERIOD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_n),
      .key_state  (key_state),
      .key_press  (key_press),
      .key_release(key_release)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: raw samples reach the FSM two edges late; a level flips after DEB+1 consecutive disagreeing edges.
   logic m_s1, m_s2;
   bit   m_level, e_press, e_rel;
   int   m_run, m_elapsed, m_thr;

   int   press_cnt, rel_cnt, press_edge, rel_edge, hi_cnt, lo_cnt;
   int   press_q[$];

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_level = 1'b0; m_run = 0;
      m_elapsed = 0; m_thr = RDELAY;
      e_press = 1'b0; e_rel = 1'b0;
   endtask

   task automatic model_edge(input logic kn);
      bit ks, stable_before;
      ks = !m_s2;
      m_s2 = m_s1;
      m_s1 = kn;
      stable_before = (m_run == 0);
      e_press = 1'b0;
      e_rel   = 1'b0;
      if (ks != m_level) begin
         m_run++;
         if (m_run == DEB + 1) begin
            m_level = ks;
            m_run = 0;
            if (ks) e_press = 1'b1;
            else    e_rel   = 1'b1;
            m_elapsed = 0;
            m_thr = RDELAY;
         end
      end else begin
`ifdef SM_KEY_DEBOUNCE_AUTOREPEAT_EN
         if (m_level && stable_before) begin
            m_elapsed++;
            if (m_elapsed == m_thr) begin
               e_press = 1'b1;
               m_elapsed = 0;
               m_thr = RPERIOD;
            end
         end
`endif
         m_run = 0;
      end
   endtask

   task automatic clear_counts();
      press_cnt = 0; rel_cnt = 0; press_edge = -1; rel_edge = -1;
      hi_cnt = 0; lo_cnt = 0;
      press_q.delete();
   endtask

   // One clock: drive the raw key, advance the model at the edge, compare on the falling edge.
   task automatic step(input logic kn);
      key_n = kn;
      @(posedge clk);
      cyc++;
      model_edge(kn);
      @(negedge clk);
      chk("key_state", key_state, m_level);
      chk("key_press", key_press, e_press);
      chk("key_release", key_release, e_rel);
      chk("exclusive", key_press & key_release, 1'b0);
      if (key_press === 1'b1) begin press_cnt++; press_edge = cyc; press_q.push_back(cyc); end
      if (key_release === 1'b1) begin rel_cnt++; rel_edge = cyc; end
      if (key_state === 1'b1) hi_cnt++;
      else lo_cnt++;
   endtask

   task automatic do_reset(input int hold_edges);
      rst_n = 1'b0;
      #1;
      chk("rst_state", key_state, 1'b0);
      chk("rst_press", key_press, 1'b0);
      chk("rst_release", key_release, 1'b0);
      repeat (hold_edges) begin
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
      chk("rst_hold_release", key_release, 1'b0);
      chk("rst_hold_state", key_state, 1'b0);
      rst_n = 1'b1;
      model_reset();
   endtask

   int n;
   logic lvl;

   initial begin
      model_reset();
      clear_counts();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("por_state", key_state, 1'b0);
      chk("por_press", key_press, 1'b0);
      chk("por_release", key_release, 1'b0);
      rst_n = 1'b1;
      repeat (5) step(1'b1);

      // Clean press: single pulse DEB+2 edges after the first low sample.
      clear_counts();
      n = cyc + 1;
      repeat (30) step(1'b0);
`ifndef SM_KEY_DEBOUNCE_AUTOREPEAT_EN
      chk_int("clean_press_count", press_cnt, 1);
      chk_int("clean_press_edge", press_edge, n + 6);
      chk_int("clean_state_cycles", hi_cnt, 30 - 6);
`endif
      repeat (12) step(1'b1);

      // Glitch shorter than the debounce window is ignored.
      clear_counts();
      repeat (3) step(1'b0);
      repeat (12) step(1'b1);
      chk_int("glitch_press", press_cnt, 0);
      chk_int("glitch_release", rel_cnt, 0);
      chk_int("glitch_state", hi_cnt, 0);

      // Bouncy release: level holds through the bounce, one release after the last rising edge.
      repeat (10) step(1'b0);
      clear_counts();
      for (int i = 0; i < 8; i++) step(((i / 2) % 2 == 0) ? 1'b1 : 1'b0);
      chk_int("bounce_state_drop", lo_cnt, 0);
      n = cyc + 1;
      repeat (12) step(1'b1);
      chk_int("bounce_release_count", rel_cnt, 1);
      chk_int("bounce_release_edge", rel_edge, n + 6);

      // Reset while held down: no release, then a fresh press after full debounce.
      repeat (10) step(1'b0);
      clear_counts();
      key_n = 1'b0;
      do_reset(2);
      n = cyc + 1;
      repeat (12) step(1'b0);
      chk_int("rst_no_release", rel_cnt, 0);
      chk_int("rst_repress_count", press_cnt, 1);
      chk_int("rst_repress_edge", press_edge, n + 6);
      repeat (12) step(1'b1);

`ifdef SM_KEY_DEBOUNCE_AUTOREPEAT_EN
      // Auto-repeat: initial press, long delay, then short period while held.
      clear_counts();
      n = cyc + 1;
      repeat (29) step(1'b0);
      repeat (12) step(1'b1);
      chk_int("rep_count", press_cnt, 6);
      if (press_q.size() == 6) begin
         chk_int("rep_edge0", press_q[0], n + 6);
         chk_int("rep_edge1", press_q[1], n + 16);
         chk_int("rep_edge2", press_q[2], n + 19);
         chk_int("rep_edge3", press_q[3], n + 22);
         chk_int("rep_edge4", press_q[4], n + 25);
         chk_int("rep_edge5", press_q[5], n + 28);
      end
      chk_int("rep_release_count", rel_cnt, 1);
`endif

      // Random bounce bursts with occasional asynchronous reset.
      for (int b = 0; b < 120; b++) begin
         lvl = logic'($urandom_range(0, 1));
         repeat ($urandom_range(1, 9)) step(lvl);
         if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 3));
      end
      repeat (12) step(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout checks=%0d", checks);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
